seq_detector_param: RTL and testbench

Parametrised serial pattern detector producing Mealy and Moore match indications from one shared prefix-tracking state machine. It generalises the fixed four-ones detector to any pattern of 2–16 bits, supports overlapping and non-overlapping detection, qualifies input bits with a valid strobe, and optionally counts matches. It sits on a serial bit stream in the lab datapath, upstream of whatever consumes match events.

---
 rtl/seq_detector_param_if.sv | 31 +++
 rtl/seq_detector_param.sv | 103 ++++++++++
 tb/tb_seq_detector_param.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param_if
// Brief    : Serial bit-stream and match-indication bundle for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) ();
  localparam int SW = $clog2(N + 1);

  logic             clr;
  logic             in_valid;
  logic             in_bit;
  logic             mealy_out;
  logic             moore_out;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_count;

  modport master (
    output clr, in_valid, in_bit,
    input  mealy_out, moore_out, state, match_count
  );

  modport slave (
    input  clr, in_valid, in_bit,
    output mealy_out, moore_out, state, match_count
  );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Parametrised serial pattern detector (Mealy + Moore outputs),
//            optional saturating match counter under SEQDET_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1111,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  seq_detector_param_if.slave   bus
);
  localparam int          SW     = $clog2(N + 1);
  localparam logic [SW-1:0] C_FULL = SW'(N);

  logic [SW-1:0] r_state;
  logic [N-2:0]  r_hist;
  logic          r_moore;
  logic [SW-1:0] w_state_next;
  logic [N-1:0]  w_hist_next;
  logic          w_match;
  int            w_limit;
  int            w_best;

  // True when the newest j bits of h equal the first j bits of PATTERN.
  function automatic logic suffix_match(input logic [N-1:0] h, input int j);
    logic [N-1:0] p;
    logic         ok;
    p  = PATTERN >> (N - j);
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i < j && h[i] != p[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_hist  <= '0;
      r_moore <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_moore <= (w_state_next == C_FULL);
      if (bus.clr)           r_hist <= '0;
      else if (bus.in_valid) r_hist <= w_hist_next[N-2:0];
    end
  end

  // Next-state: the longest prefix may grow by at most one bit per valid bit,
  // and a non-overlapping restart from the full state may only reach length 1.
  always_comb begin
    w_hist_next  = {r_hist, bus.in_bit};
    w_limit      = 0;
    w_best       = 0;
    w_state_next = r_state;
    if (bus.clr) begin
      w_state_next = '0;
    end else if (bus.in_valid) begin
      if (r_state == C_FULL) w_limit = OVERLAP ? N : 1;
      else                   w_limit = int'(r_state) + 1;
      for (int j = 1; j <= N; j++) begin
        if (j <= w_limit && suffix_match(w_hist_next, j)) w_best = j;
      end
      w_state_next = SW'(w_best);
    end
  end

  // Outputs
  always_comb begin
    w_match = bus.in_valid & ~bus.clr & (w_state_next == C_FULL) &
              (OVERLAP | (r_state != C_FULL));
  end

  assign bus.mealy_out = w_match;
  assign bus.moore_out = r_moore;
  assign bus.state     = r_state;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.clr) begin
      r_count <= '0;
    end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.match_count = r_count;
`else
  assign bus.match_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Directed self-checking bench for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  seq_detector_param_if #(.N(4), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.N(4), .CNT_W(8)) ifb ();
  seq_detector_param_if #(.N(4), .CNT_W(2)) ifc ();
  seq_detector_param_if #(.N(4), .CNT_W(8)) ifd ();

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  seq_detector_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  seq_detector_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8))
    u_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic c; logic v; logic b;
    logic am; int as; logic bm; int bs; int ac; int bc;
  } vec_t;

  vec_t tbl [22];

  function automatic int exp_cnt(input int x);
`ifdef SEQDET_COUNT_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  task automatic drive(input logic c, input logic v, input logic b);
    ifa.clr = c; ifa.in_valid = v; ifa.in_bit = b;
    ifb.clr = c; ifb.in_valid = v; ifb.in_bit = b;
    ifc.clr = c; ifc.in_valid = v; ifc.in_bit = b;
    ifd.clr = c; ifd.in_valid = v; ifd.in_bit = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // {clr,valid,bit, A mealy,A state, B mealy,B state, A count,B count}
    tbl[0]  = '{1'b0,1'b1,1'b1, 1'b0,1, 1'b0,1, 0,0};
    tbl[1]  = '{1'b0,1'b1,1'b0, 1'b0,2, 1'b0,2, 0,0};
    tbl[2]  = '{1'b0,1'b1,1'b1, 1'b0,3, 1'b0,3, 0,0};
    tbl[3]  = '{1'b0,1'b1,1'b1, 1'b1,4, 1'b1,4, 1,1};
    tbl[4]  = '{1'b0,1'b1,1'b0, 1'b0,2, 1'b0,0, 1,1};
    tbl[5]  = '{1'b0,1'b1,1'b1, 1'b0,3, 1'b0,1, 1,1};
    tbl[6]  = '{1'b0,1'b1,1'b1, 1'b1,4, 1'b0,1, 2,1};
    tbl[7]  = '{1'b0,1'b0,1'b1, 1'b0,4, 1'b0,1, 2,1};
    tbl[8]  = '{1'b1,1'b1,1'b1, 1'b0,0, 1'b0,0, 0,0};
    tbl[9]  = '{1'b0,1'b1,1'b1, 1'b0,1, 1'b0,1, 0,0};
    tbl[10] = '{1'b0,1'b0,1'b0, 1'b0,1, 1'b0,1, 0,0};
    tbl[11] = '{1'b0,1'b0,1'b1, 1'b0,1, 1'b0,1, 0,0};
    tbl[12] = '{1'b0,1'b0,1'b0, 1'b0,1, 1'b0,1, 0,0};
    tbl[13] = '{1'b0,1'b1,1'b0, 1'b0,2, 1'b0,2, 0,0};
    tbl[14] = '{1'b0,1'b1,1'b1, 1'b0,3, 1'b0,3, 0,0};
    tbl[15] = '{1'b0,1'b1,1'b1, 1'b1,4, 1'b1,4, 1,1};
    tbl[16] = '{1'b0,1'b0,1'b0, 1'b0,4, 1'b0,4, 1,1};
    tbl[17] = '{1'b0,1'b0,1'b1, 1'b0,4, 1'b0,4, 1,1};
    tbl[18] = '{1'b0,1'b0,1'b0, 1'b0,4, 1'b0,4, 1,1};
    tbl[19] = '{1'b0,1'b0,1'b1, 1'b0,4, 1'b0,4, 1,1};
    tbl[20] = '{1'b0,1'b0,1'b0, 1'b0,4, 1'b0,4, 1,1};
    tbl[21] = '{1'b0,1'b1,1'b0, 1'b0,2, 1'b0,0, 1,1};

    #12;
    chk("reset a_state", int'(ifa.state), 0);
    chk("reset a_moore", int'(ifa.moore_out), 0);
    chk("reset a_mealy", int'(ifa.mealy_out), 0);
    chk("reset a_count", int'(ifa.match_count), 0);
    chk("reset c_state", int'(ifc.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].b);
      #1;
      chk($sformatf("row%0d a_mealy", i), int'(ifa.mealy_out), int'(tbl[i].am));
      chk($sformatf("row%0d b_mealy", i), int'(ifb.mealy_out), int'(tbl[i].bm));
      tick();
      chk($sformatf("row%0d a_state", i), int'(ifa.state), tbl[i].as);
      chk($sformatf("row%0d b_state", i), int'(ifb.state), tbl[i].bs);
      chk($sformatf("row%0d a_moore", i), int'(ifa.moore_out), int'(tbl[i].as == 4));
      chk($sformatf("row%0d b_moore", i), int'(ifb.moore_out), int'(tbl[i].bs == 4));
      chk($sformatf("row%0d a_count", i), int'(ifa.match_count), exp_cnt(tbl[i].ac));
      chk($sformatf("row%0d b_count", i), int'(ifb.match_count), exp_cnt(tbl[i].bc));
    end

    // Asynchronous reset mid-pattern
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1); tick();
    chk("pre-rst a_state", int'(ifa.state), 3);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async rst a_state", int'(ifa.state), 0);
    chk("async rst b_state", int'(ifb.state), 0);
    #2;
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b1, 1'b1);
    #1;
    chk("post-rst bit1 a_mealy", int'(ifa.mealy_out), 0);
    tick();
    chk("post-rst bit1 a_state", int'(ifa.state), 1);
    drive(1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b1);
    #1;
    chk("post-rst full a_mealy", int'(ifa.mealy_out), 1);
    tick();
    chk("post-rst full a_count", int'(ifa.match_count), exp_cnt(1));

    // Runs of ones: overlap on C (saturating 2-bit count), non-overlap on D
    drive(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      #1;
      chk($sformatf("ones%0d c_mealy", i), int'(ifc.mealy_out), int'(i >= 3));
      chk($sformatf("ones%0d d_mealy", i), int'(ifd.mealy_out), int'(i % 4 == 3));
      tick();
      chk($sformatf("ones%0d c_state", i), int'(ifc.state), (i < 3) ? i + 1 : 4);
      chk($sformatf("ones%0d d_state", i), int'(ifd.state), (i % 4) + 1);
      chk($sformatf("ones%0d c_count", i), int'(ifc.match_count),
          exp_cnt((i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2)));
      chk($sformatf("ones%0d d_count", i), int'(ifd.match_count), exp_cnt((i + 1) / 4));
    end

    // clr beats a completing valid bit
    drive(1'b1, 1'b1, 1'b1);
    #1;
    chk("clr c_mealy", int'(ifc.mealy_out), 0);
    tick();
    chk("clr c_state", int'(ifc.state), 0);
    chk("clr c_moore", int'(ifc.moore_out), 0);
    chk("clr c_count", int'(ifc.match_count), 0);
    chk("clr d_state", int'(ifd.state), 0);
    drive(1'b0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
